// File: rtl/seq_det_stream_ctrl.sv
// Serialises valid/ready words MSB-first into a Mealy sequence detector, owns its reset and counts qualified hits.
// Optional macro SEQ_CTRL_GAP_RST_EN: hold the detector in reset on every idle cycle so patterns cannot span gaps.
module seq_det_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_in,
  output logic              det_rst,
  input  logic              det_in,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              thresh_irq,
  output logic              busy,
  output logic              state_dbg
);

  localparam int BC_W = $clog2(DATA_W);

`ifdef SEQ_CTRL_GAP_RST_EN
  localparam logic GAP_RST = 1'b1;
`else
  localparam logic GAP_RST = 1'b0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic              ser_vld;
  logic              last_bit;
  logic              accept;
  logic              go_idle;
  logic              hit;
  logic              cnt_max;
  logic [CNT_W-1:0]  cnt_inc;

  // Handshake: a word transfers on any rising edge where in_valid and in_ready
  // are both high; in_ready never depends on in_valid, and in_data need not be
  // held while in_ready is low.
  assign last_bit  = (state == SHIFT) && (bit_cnt == '0);
  assign in_ready  = !rst && ((state == IDLE) || last_bit);
  assign accept    = in_valid && in_ready;
  assign go_idle   = !accept && ((state == IDLE) || last_bit);
  assign hit       = ser_vld && det_in;
  assign cnt_max   = &hit_cnt;
  assign cnt_inc   = hit_cnt + CNT_W'(1);
  assign busy      = (state != IDLE);
  assign state_dbg = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      ser_in     <= 1'b0;
      ser_vld    <= 1'b0;
      det_rst    <= 1'b1;
      hit_cnt    <= '0;
      thresh_irq <= 1'b0;
    end else begin
      // A clear also flushes the detector so stale partial patterns are dropped.
      det_rst <= clr_cnt || (GAP_RST && go_idle);

      if (accept) begin
        state   <= SHIFT;
        shreg   <= {in_data[DATA_W-2:0], 1'b0};
        ser_in  <= in_data[DATA_W-1];
        ser_vld <= 1'b1;
        bit_cnt <= BC_W'(DATA_W - 1);
      end else if ((state == SHIFT) && !last_bit) begin
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        ser_in  <= shreg[DATA_W-1];
        bit_cnt <= bit_cnt - BC_W'(1);
      end else begin
        state   <= IDLE;
        ser_in  <= 1'b0;
        ser_vld <= 1'b0;
      end

      // det_in is only meaningful for bits we actually shifted out.
      if (clr_cnt) begin
        hit_cnt    <= '0;
        thresh_irq <= 1'b0;
      end else if (hit && !cnt_max) begin
        hit_cnt    <= cnt_inc;
        thresh_irq <= (cfg_thresh != '0) && (cnt_inc == cfg_thresh);
      end else begin
        thresh_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Bench for seq_det_stream_ctrl: overlapping "101" Mealy detector in the loop, bit-stream scoreboard plus hit/irq model.
module tb_seq_det_stream_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef SEQ_CTRL_GAP_RST_EN
  localparam bit GAP_MODE = 1'b1;
`else
  localparam bit GAP_MODE = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_in;
  logic              det_rst;
  logic              det_in;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              clr_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic              thresh_irq;
  logic              busy;
  logic              state_dbg;

  always #5 clk = ~clk;

  seq_det_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_in     (ser_in),
    .det_rst    (det_rst),
    .det_in     (det_in),
    .cfg_thresh (cfg_thresh),
    .clr_cnt    (clr_cnt),
    .hit_cnt    (hit_cnt),
    .thresh_irq (thresh_irq),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Detector attached to the controller: overlapping "101", Mealy output.
  logic [1:0] det_h = 2'b00;
  assign det_in = ser_in & det_h[1] & ~det_h[0];
  always @(posedge clk) det_h <= det_rst ? 2'b00 : {det_h[0], ser_in};

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  bit  seg[$];
  int  bits_due   = 0;
  bit  acc_pend   = 1'b0;
  bit  flush_pend = 1'b1;
  bit  mon_en     = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;
  bit  exp_irq    = 1'b0;
  int  irq_seen   = 0;
  bit  cur_vld, cur_bit, cur_dr, pat, hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle compares DUT outputs with the model, then advances the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_pend) bits_due += DATA_W;
      cur_vld = (bits_due > 0);
      cur_bit = 1'b0;
      if (cur_vld) begin
        check("word_queued", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) cur_bit = exp_q.pop_front();
      end
      cur_dr = flush_pend || (GAP_MODE && !cur_vld);

      check("ser_in",     32'(ser_in),     32'(cur_bit));
      check("busy",       32'(busy),       32'(cur_vld));
      check("state_dbg",  32'(state_dbg),  32'(cur_vld));
      check("in_ready",   32'(in_ready),   32'(!rst && bits_due <= 1));
      check("det_rst",    32'(det_rst),    32'(cur_dr));
      check("hit_cnt",    32'(hit_cnt),    32'(exp_cnt));
      check("thresh_irq", 32'(thresh_irq), 32'(exp_irq));
      if (thresh_irq) irq_seen++;

      pat = (seg.size() >= 2) && seg[seg.size()-2] && !seg[seg.size()-1] && cur_bit;
      hit = cur_vld && pat;
      acc_pend = in_valid && !rst && (bits_due <= 1);
      if (cur_vld) bits_due--;

      if (rst) begin
        exp_q.delete();
        seg.delete();
        bits_due   = 0;
        acc_pend   = 1'b0;
        exp_cnt    = '0;
        exp_irq    = 1'b0;
        flush_pend = 1'b1;
      end else begin
        if (cur_dr) seg.delete();
        else begin
          seg.push_back(cur_bit);
          if (seg.size() > 2) void'(seg.pop_front());
        end
        exp_irq = 1'b0;
        if (clr_cnt) exp_cnt = '0;
        else if (hit && exp_cnt != CNT_MAX) begin
          exp_cnt = exp_cnt + 1'b1;
          exp_irq = (cfg_thresh != '0) && (exp_cnt == cfg_thresh);
        end
        flush_pend = clr_cnt;
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send_word(input logic [DATA_W-1:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waited < 4 * DATA_W) begin
      @(negedge clk);
      waited++;
    end
    check("send_accept", 32'(in_ready), 32'd1);
    if (in_ready) for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0; cfg_thresh = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    idle(5);
    check("rst_ser_in",   32'(ser_in),   32'd0);
    check("rst_det_rst",  32'(det_rst),  32'(GAP_MODE));
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_hit_cnt",  32'(hit_cnt),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);

    // single word
    send_word(8'hAA); idle(DATA_W + 1);
    check("aa_hits", 32'(hit_cnt), 32'd3);

    // back-to-back words
    clear();
    send_word(8'hA0); send_word(8'h05); idle(DATA_W + 1);
    check("b2b_hits", 32'(hit_cnt), 32'd2);

    // one gap zero between words
    clear();
    send_word(8'h01); idle(DATA_W); send_word(8'h80); idle(DATA_W + 1);
    check("gap_hits", 32'(hit_cnt), GAP_MODE ? 32'd0 : 32'd1);

    // threshold interrupt
    cfg_thresh = 4'd3;
    clear(); irq_seen = 0;
    send_word(8'hAA); idle(DATA_W + 1);
    send_word(8'hAA); idle(DATA_W + 1);
    check("thr_irq_pulses", 32'(irq_seen), 32'd1);
    check("thr_hits",       32'(hit_cnt),  32'd6);

    // clear coincident with a hit (third bit of 0xAA completes "101")
    cfg_thresh = '0;
    send_word(8'hAA);
    idle(2);
    clear();
    @(negedge clk);
    check("clr_vs_hit", 32'(hit_cnt), 32'd0);
    idle(DATA_W + 1);
    check("clr_after_hits", 32'(hit_cnt), 32'd1);

    // saturation: threshold at all-ones fires once, then holds
    cfg_thresh = CNT_MAX;
    clear(); irq_seen = 0;
    repeat (6) send_word(8'hAA);
    idle(DATA_W + 1);
    check("sat_hits", 32'(hit_cnt),  32'(CNT_MAX));
    check("sat_irq",  32'(irq_seen), 32'd1);

    // reset on the 4th bit of 0xFF
    cfg_thresh = '0;
    send_word(8'hFF);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_ser_in",   32'(ser_in),   32'd0);
    check("mid_rst_hit_cnt",  32'(hit_cnt),  32'd0);
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_ready_lo", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    send_word(8'hA5); idle(DATA_W + 1);
    check("post_rst_hits", 32'(hit_cnt), 32'd2);

    // randomized traffic
    clear();
    for (int n = 0; n < 60; n++) begin
      if (n % 10 == 0) cfg_thresh = CNT_W'($urandom_range(0, 15));
      if (n >= 30 && $urandom_range(0, 7) == 0) clear();
      send_word(DATA_W'($urandom));
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(DATA_W + gap - 1);
    end
    idle(DATA_W + 2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
